// File: rtl/cmp2s_rr_arbiter.sv
// Round-robin arbiter that feeds one shared 2's-complement negator and returns tagged results.
// Define CMP2S_ARB_STATS_EN to add the consumed-response counters stat_cnt / stat_ovf_cnt.

module cmp2s_neg #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] op,
   output logic [WIDTH-1:0] neg,
   output logic             ovf
);
   assign neg = ~op + WIDTH'(1);
   assign ovf = (op == {1'b1, {(WIDTH-1){1'b0}}});
endmodule

module cmp2s_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 4,
   parameter int ID_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   output logic [WIDTH-1:0]       rsp_data,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   rsp_ovf,
   input  logic                   rsp_ready
`ifdef CMP2S_ARB_STATS_EN
   ,
   output logic [15:0]            stat_cnt,
   output logic [15:0]            stat_ovf_cnt
`endif
);

   typedef enum logic {S_IDLE, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic              rsp_ovf_q, rsp_ovf_d;

   logic              accept, grant, gnt_found;
   logic [ID_W-1:0]   gnt_idx;
   logic [ID_W:0]     cand;
   logic [WIDTH-1:0]  gnt_op, neg_data;
   logic              neg_ovf;

   // Rotating priority search starting at ptr; cand carries one extra bit so the wrap is a single subtract.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
         if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      gnt_op = '0;
      for (int i = 0; i < N_REQ; i++)
         if (ID_W'(i) == gnt_idx) gnt_op = req_data[i*WIDTH +: WIDTH];
   end

   cmp2s_neg #(.WIDTH(WIDTH)) u_neg (
      .op  (gnt_op),
      .neg (neg_data),
      .ovf (neg_ovf)
   );

   assign accept = (state_q == S_IDLE) || rsp_ready;
   assign grant  = accept && gnt_found && !rst;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (grant) state_d = S_RESP;
         S_RESP: if (!grant && rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      req_ready = '0;
      if (grant) req_ready[gnt_idx] = 1'b1;
      rsp_valid = (state_q == S_RESP);
   end

   always_comb begin
      ptr_d      = ptr_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      rsp_ovf_d  = rsp_ovf_q;
      if (grant) begin
         ptr_d      = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
         rsp_data_d = neg_data;
         rsp_id_d   = gnt_idx;
         rsp_ovf_d  = neg_ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
         rsp_ovf_q  <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         rsp_ovf_q  <= rsp_ovf_d;
      end
   end

   assign rsp_data = rsp_data_q;
   assign rsp_id   = rsp_id_q;
   assign rsp_ovf  = rsp_ovf_q;

`ifdef CMP2S_ARB_STATS_EN
   logic [15:0] stat_cnt_q, stat_cnt_d, stat_ovf_cnt_q, stat_ovf_cnt_d;
   logic        consumed;

   assign consumed = (state_q == S_RESP) && rsp_ready;

   // Saturating counters of responses actually taken by the consumer.
   always_comb begin
      stat_cnt_d     = stat_cnt_q;
      stat_ovf_cnt_d = stat_ovf_cnt_q;
      if (consumed && stat_cnt_q != 16'hFFFF) stat_cnt_d = stat_cnt_q + 16'd1;
      if (consumed && rsp_ovf_q && stat_ovf_cnt_q != 16'hFFFF) stat_ovf_cnt_d = stat_ovf_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_cnt_q     <= '0;
         stat_ovf_cnt_q <= '0;
      end else begin
         stat_cnt_q     <= stat_cnt_d;
         stat_ovf_cnt_q <= stat_ovf_cnt_d;
      end
   end

   assign stat_cnt     = stat_cnt_q;
   assign stat_ovf_cnt = stat_ovf_cnt_q;
`endif

endmodule

// File: tb/tb_cmp2s_rr_arbiter.sv
// Self-checking bench for cmp2s_rr_arbiter: directed pins plus random traffic against a behavioural model.
// Checks the stat counters too when CMP2S_ARB_STATS_EN is defined.

module tb_cmp2s_rr_arbiter;
   localparam int N = 4, W = 4, IW = 2;

   logic           clk = 1'b0;
   logic           rst, rsp_ready, rsp_valid, rsp_ovf;
   logic [N-1:0]   req_valid, req_ready;
   logic [N*W-1:0] req_data;
   logic [W-1:0]   rsp_data;
   logic [IW-1:0]  rsp_id;
`ifdef CMP2S_ARB_STATS_EN
   logic [15:0]    stat_cnt, stat_ovf_cnt;
`endif

   always #5 clk = ~clk;

   cmp2s_rr_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ovf   (rsp_ovf),
      .rsp_ready (rsp_ready)
`ifdef CMP2S_ARB_STATS_EN
      ,
      .stat_cnt     (stat_cnt),
      .stat_ovf_cnt (stat_ovf_cnt)
`endif
   );

   int n_vec = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: the values the DUT outputs must show after the next rising edge.
   int m_ptr = 0, m_data = 0, m_id = 0, m_cnt = 0, m_ocnt = 0;
   bit m_held = 0, m_ovf = 0, seen_rst = 0;

   always @(negedge clk) begin
      int g, op;
      logic [N-1:0] exp_rdy;
      g = -1;
      if (!rst && (!m_held || rsp_ready))
         for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      if (seen_rst) begin
         chk("m_req_ready", req_ready, exp_rdy);
         chk("m_rsp_valid", rsp_valid, m_held);
         chk("m_rsp_data",  rsp_data,  m_data);
         chk("m_rsp_id",    rsp_id,    m_id);
         chk("m_rsp_ovf",   rsp_ovf,   m_ovf);
`ifdef CMP2S_ARB_STATS_EN
         chk("m_stat_cnt",     stat_cnt,     m_cnt);
         chk("m_stat_ovf_cnt", stat_ovf_cnt, m_ocnt);
`endif
      end
      if (rst) begin
         seen_rst = 1; m_ptr = 0; m_held = 0; m_data = 0; m_id = 0; m_ovf = 0;
         m_cnt = 0; m_ocnt = 0;
      end else begin
         if (m_held && rsp_ready) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_ovf && m_ocnt < 65535) m_ocnt++;
         end
         if (g >= 0) begin
            op     = int'(req_data[g*W +: W]);
            m_data = ((1 << W) - op) % (1 << W);
            m_ovf  = (op == (1 << (W-1)));
            m_id   = g;
            m_held = 1;
            m_ptr  = (g + 1) % N;
         end else if (m_held && rsp_ready) begin
            m_held = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic single(input int idx, input int op, input int exp_d, input int exp_o);
      req_valid = '0;
      req_valid[idx] = 1'b1;
      req_data[idx*W +: W] = W'(op);
      rsp_ready = 1'b1;
      step();
      req_valid = '0;
      @(negedge clk);
      chk("bnd_valid", rsp_valid, 1);
      chk("bnd_data",  rsp_data,  exp_d);
      chk("bnd_ovf",   rsp_ovf,   exp_o);
      step();
   endtask

   int rr_data[4] = '{15, 14, 13, 12};

   initial begin
      rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
      step(); step(); step();
      rst = 1'b0;

      repeat (3) begin
         @(negedge clk);
         chk("idle_valid", rsp_valid, 0);
         chk("idle_ready", req_ready, 0);
         chk("idle_data",  rsp_data,  0);
         chk("idle_id",    rsp_id,    0);
      end
      step();

      req_valid = 4'b0100; req_data = 16'h0500; rsp_ready = 1'b1;
      @(negedge clk);
      chk("single_grant", req_ready, 4'b0100);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("single_valid", rsp_valid, 1);
      chk("single_data",  rsp_data,  11);
      chk("single_id",    rsp_id,    2);
      chk("single_ovf",   rsp_ovf,   0);
      step();
      @(negedge clk);
      chk("single_drop", rsp_valid, 0);
      step();

      rst = 1'b1; step(); rst = 1'b0;
      req_valid = 4'b1111; req_data = 16'h4321; rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("rr_grant", req_ready, 32'(1) << (c % 4));
         if (c >= 1) begin
            chk("rr_valid", rsp_valid, 1);
            chk("rr_data",  rsp_data,  rr_data[(c-1) % 4]);
            chk("rr_id",    rsp_id,    (c-1) % 4);
         end
         step();
      end

      rsp_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_ready", req_ready, 0);
         chk("bp_valid", rsp_valid, 1);
         chk("bp_data",  rsp_data,  14);
         chk("bp_id",    rsp_id,    1);
         step();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_resume", req_ready, 4'b0100);
      step();
      req_valid = '0; step(); step();

      rst = 1'b1; step(); rst = 1'b0;
      single(0, 8, 8, 1);
      single(1, 0, 0, 0);
      single(2, 15, 1, 0);
`ifdef CMP2S_ARB_STATS_EN
      @(negedge clk);
      chk("stat_cnt",     stat_cnt,     3);
      chk("stat_ovf_cnt", stat_ovf_cnt, 1);
      step();
`endif

      req_valid = 4'b0010; req_data = 16'h0030; rsp_ready = 1'b0;
      step();
      req_valid = '0; step();
      rst = 1'b1; step(); rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data",  rsp_data,  0);
      step();
      req_valid = 4'b1111; rsp_ready = 1'b1;
      @(negedge clk);
      chk("rst_ptr_grant", req_ready, 4'b0001);
      step();
      req_valid = '0; step(); step();

      repeat (800) begin
         rst       = ($urandom_range(0, 63) == 0);
         req_valid = N'($urandom);
         req_data  = (N*W)'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
